// File: rtl/eth_clk_div_gen_pkg.sv
// Shared types and constants for the Ethernet quadrature clock generator.
package eth_clk_pkg;

  typedef enum logic {
    CLK_STOPPED,
    CLK_RUN
  } clk_state_e;

  // Quarter-period presets for a 500 MHz source clock.
  localparam int unsigned Q_125M = 1;
  localparam int unsigned Q_25M  = 5;
  localparam int unsigned Q_2M5  = 50;

  // Phase index to {clk0, clk90, clk180, clk270}.
  function automatic logic [3:0] phase_decode(input logic [1:0] phase);
    logic [3:0] dec;
    dec = 4'b0011;
    case (phase)
      2'd0:    dec = 4'b1001;
      2'd1:    dec = 4'b1100;
      2'd2:    dec = 4'b0110;
      default: dec = 4'b0011;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/eth_clk_div_gen.sv
// Programmable quadrature clock generator (0/90/180/270 deg) with a
// run-time quarter-period. Divisor changes and start/stop only take effect
// at period boundaries so no output pulse is shorter than one quarter.
// Optional macro ETH_CLK_DIV_GEN_CFG_CHECK_EN: reject Q=0 requests with a
// cfg_err_o pulse instead of clamping them to 1.
module eth_clk_div_gen
  import eth_clk_pkg::*;
#(
  parameter int unsigned QuarterWidth = 8,
  parameter int unsigned ResetQuarter = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    cfg_valid_i,
  input  logic [QuarterWidth-1:0] cfg_quarter_i,
  output logic                    cfg_ready_o,
  output logic                    cfg_err_o,
  output logic                    upd_o,
  output logic                    running_o,
  output logic                    clk0_o,
  output logic                    clk90_o,
  output logic                    clk180_o,
  output logic                    clk270_o
);

  localparam logic [QuarterWidth-1:0] RstQ = QuarterWidth'(ResetQuarter);
  localparam logic [QuarterWidth-1:0] QOne = QuarterWidth'(1);

  clk_state_e              state_q, state_d;
  logic [1:0]              phase_q, phase_d;
  logic [QuarterWidth-1:0] qcnt_q, qcnt_d;
  logic [QuarterWidth-1:0] q_q, q_d;
  logic [QuarterWidth-1:0] pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    upd_q, upd_d;
  logic [3:0]              clk_q, clk_d;
  logic                    req_err;
  logic                    apply;
  logic                    q_last;
  logic                    cfg_xfer;

  // State register: FSM, counters, configuration slot and phase outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= CLK_STOPPED;
      phase_q      <= 2'd3;
      qcnt_q       <= '0;
      q_q          <= RstQ;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      upd_q        <= 1'b0;
      clk_q        <= phase_decode(2'd3);
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      qcnt_q       <= qcnt_d;
      q_q          <= q_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      upd_q        <= upd_d;
      clk_q        <= clk_d;
    end
  end

  // Next-state: quarter counter, phase stepping, boundary apply and handshake.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    qcnt_d       = qcnt_q;
    q_d          = q_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    upd_d        = 1'b0;
    req_err      = 1'b0;
    apply        = 1'b0;
    q_last       = (qcnt_q == (q_q - QOne));
    cfg_xfer     = cfg_valid_i && !pend_valid_q;

    unique case (state_q)
      CLK_STOPPED: begin
        if (en_i) begin
          state_d = CLK_RUN;
          phase_d = 2'd0;
          qcnt_d  = '0;
          apply   = 1'b1;
        end
      end
      CLK_RUN: begin
        if (q_last) begin
          qcnt_d = '0;
          if (phase_q == 2'd3) begin
            apply = 1'b1;
            if (en_i) phase_d = 2'd0;
            else      state_d = CLK_STOPPED;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          qcnt_d = qcnt_q + QOne;
        end
      end
      default: state_d = CLK_STOPPED;
    endcase

    // Apply uses the slot's old contents; a handshake in the same cycle can
    // only happen when the slot was empty, so it lands for the next boundary.
    if (apply && pend_valid_q) begin
      q_d          = pend_q;
      pend_valid_d = 1'b0;
      upd_d        = 1'b1;
    end

    if (cfg_xfer) begin
`ifdef ETH_CLK_DIV_GEN_CFG_CHECK_EN
      if (cfg_quarter_i == '0) begin
        req_err = 1'b1;
      end else begin
        pend_d       = cfg_quarter_i;
        pend_valid_d = 1'b1;
      end
`else
      pend_d       = (cfg_quarter_i == '0) ? QOne : cfg_quarter_i;
      pend_valid_d = 1'b1;
`endif
    end

    clk_d = phase_decode(phase_d);
  end

`ifdef ETH_CLK_DIV_GEN_CFG_CHECK_EN
  logic err_q;

  // One-cycle error pulse for a rejected zero request.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= req_err;
  end

  assign cfg_err_o = err_q;
`else
  logic unused_err;
  assign unused_err = req_err;
  assign cfg_err_o  = 1'b0;
`endif

  assign cfg_ready_o = !pend_valid_q;
  assign upd_o       = upd_q;
  assign running_o   = (state_q == CLK_RUN);
  assign clk0_o      = clk_q[3];
  assign clk90_o     = clk_q[2];
  assign clk180_o    = clk_q[1];
  assign clk270_o    = clk_q[0];

endmodule

// File: tb/tb_eth_clk_div_gen.sv
// Self-checking bench for eth_clk_div_gen: per-cycle scoreboard against a
// cycle-level model plus directed scenario checks.
module tb_eth_clk_div_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_quarter;
  logic       cfg_ready, cfg_err, upd, running;
  logic       clk0, clk90, clk180, clk270;

  int errors = 0;
  int checks = 0;

  eth_clk_div_gen #(.QuarterWidth(8), .ResetQuarter(1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .cfg_valid_i  (cfg_valid),
    .cfg_quarter_i(cfg_quarter),
    .cfg_ready_o  (cfg_ready),
    .cfg_err_o    (cfg_err),
    .upd_o        (upd),
    .running_o    (running),
    .clk0_o       (clk0),
    .clk90_o      (clk90),
    .clk180_o     (clk180),
    .clk270_o     (clk270)
  );

  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  // {clk0, clk90, clk180, clk270, running, ready, upd, err}
  typedef logic [7:0] obs_t;
  obs_t exp_q[$];

  bit m_run, m_pv, m_upd, m_err, m_xfer, m_apply, m_newphase;
  int m_phase, m_left, m_q, m_pend;

  always @(posedge clk) begin
    obs_t e;
    if (rst) begin
      m_run = 0; m_phase = 3; m_left = 1; m_q = 1;
      m_pv = 0; m_pend = 0; m_upd = 0; m_err = 0;
    end else begin
      m_xfer = cfg_valid && !m_pv;
      m_apply = 0; m_newphase = 0; m_upd = 0; m_err = 0;
      if (!m_run) begin
        if (en) begin m_run = 1; m_phase = 0; m_apply = 1; m_newphase = 1; end
      end else if (m_left == 1) begin
        m_newphase = 1;
        if (m_phase == 3) begin
          m_apply = 1;
          if (en) m_phase = 0;
          else    m_run = 0;
        end else begin
          m_phase = m_phase + 1;
        end
      end else begin
        m_left = m_left - 1;
      end
      if (m_apply && m_pv) begin m_q = m_pend; m_pv = 0; m_upd = 1; end
      if (m_newphase) m_left = m_q;
      if (m_xfer) begin
`ifdef ETH_CLK_DIV_GEN_CFG_CHECK_EN
        if (cfg_quarter == 0) m_err = 1;
        else begin m_pend = cfg_quarter; m_pv = 1; end
`else
        m_pend = (cfg_quarter == 0) ? 1 : int'(cfg_quarter);
        m_pv = 1;
`endif
      end
    end
    e[7] = (m_phase == 0) || (m_phase == 1);
    e[6] = (m_phase == 1) || (m_phase == 2);
    e[5] = (m_phase == 2) || (m_phase == 3);
    e[4] = (m_phase == 3) || (m_phase == 0);
    e[3] = m_run;
    e[2] = !m_pv;
    e[1] = m_upd;
    e[0] = m_err;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e, o;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = {clk0, clk90, clk180, clk270, running, cfg_ready, upd, cfg_err};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got=%b expected=%b", $time, o, e);
      end
    end
  end

  // ---------------- helpers (no comparisons) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_upd(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (upd === 1'b1) begin seen = 1; break; end
    end
  endtask

  task automatic measure_high(output int n);
    n = 0;
    while (clk0 === 1'b1 && n < 1000) begin n++; step(); end
  endtask

  task automatic measure_low(output int n);
    n = 0;
    while (clk0 === 1'b0 && n < 1000) begin n++; step(); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; en = 0; cfg_valid = 0; cfg_quarter = 0;
    step(); step();
    rst = 0;
    checks++; if ({clk0, clk90, clk180, clk270} !== 4'b0011) begin errors++;
      $display("FAIL reset_clks got=%b expected=0011", {clk0, clk90, clk180, clk270}); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b expected=0", running); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b expected=1", cfg_ready); end
    checks++; if ({upd, cfg_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b expected=00", {upd, cfg_err}); end
  endtask

  task automatic test_q1_run();
    logic [7:0] exp0, exp90;
    exp0  = 8'b1001_1001;
    exp90 = 8'b1100_1100;
    en = 1;
    step();
    checks++; if ({clk0, clk90, running} !== 3'b101) begin errors++;
      $display("FAIL start_latency got=%b expected=101", {clk0, clk90, running}); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (clk0 !== exp0[7-i] || clk90 !== exp90[7-i] ||
          clk180 !== ~exp0[7-i] || clk270 !== ~exp90[7-i]) begin
        errors++;
        $display("FAIL q1_wave cyc=%0d got=%b expected=%b", i, {clk0, clk90, clk180, clk270},
                 {exp0[7-i], exp90[7-i], ~exp0[7-i], ~exp90[7-i]});
      end
    end
  endtask

  task automatic test_divisor_change();
    bit seen; int n;
    cfg_valid = 1; cfg_quarter = 8'd5;
    step();
    cfg_valid = 0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL chg_ready got=%b expected=0", cfg_ready); end
    wait_upd(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL chg_upd got=none expected=pulse"); end
    checks++; if ({clk0, clk90, cfg_ready} !== 3'b101) begin errors++;
      $display("FAIL chg_phase0 got=%b expected=101", {clk0, clk90, cfg_ready}); end
    measure_high(n);
    checks++; if (n != 10) begin errors++; $display("FAIL chg_high got=%0d expected=10", n); end
    measure_low(n);
    checks++; if (n != 10) begin errors++; $display("FAIL chg_low got=%0d expected=10", n); end
  endtask

  task automatic test_stop_restart();
    int n;
    repeat (5) step();
    checks++; if ({clk0, clk90} !== 2'b11) begin errors++;
      $display("FAIL stop_phase1 got=%b expected=11", {clk0, clk90}); end
    en = 0;
    n = 0;
    while (running === 1'b1 && n < 40) begin n++; step(); end
    checks++; if (n != 15) begin errors++; $display("FAIL stop_cycles got=%0d expected=15", n); end
    checks++; if ({clk0, clk90, clk180, clk270} !== 4'b0011) begin errors++;
      $display("FAIL stop_freeze got=%b expected=0011", {clk0, clk90, clk180, clk270}); end
    repeat (3) step();
    checks++; if ({clk0, clk90, clk180, clk270, running} !== 5'b00110) begin errors++;
      $display("FAIL stop_hold got=%b expected=00110", {clk0, clk90, clk180, clk270, running}); end
    en = 1;
    step();
    checks++; if ({clk0, clk90, running} !== 3'b101) begin errors++;
      $display("FAIL restart got=%b expected=101", {clk0, clk90, running}); end
  endtask

  task automatic test_back_to_back_cfg();
    bit seen; int n;
    cfg_valid = 1; cfg_quarter = 8'd3;
    step();
    cfg_quarter = 8'd7;  // held while the slot is full: must not transfer yet
    checks++; if ({cfg_ready, upd} !== 2'b00) begin errors++;
      $display("FAIL pend_full got=%b expected=00", {cfg_ready, upd}); end
    wait_upd(40, seen);
    checks++; if (!seen) begin errors++; $display("FAIL pend_upd1 got=none expected=pulse"); end
    checks++; if ({cfg_ready, clk0} !== 2'b11) begin errors++;
      $display("FAIL pend_free got=%b expected=11", {cfg_ready, clk0}); end
    step();
    cfg_valid = 0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pend_second got=%b expected=0", cfg_ready); end
    // one high cycle already consumed: Q=3 gives 6 high cycles in total
    measure_high(n);
    checks++; if (n != 5) begin errors++; $display("FAIL pend_q3_high got=%0d expected=5", n); end
    wait_upd(40, seen);
    checks++; if (!seen) begin errors++; $display("FAIL pend_upd2 got=none expected=pulse"); end
    measure_high(n);
    checks++; if (n != 14) begin errors++; $display("FAIL pend_q7_high got=%0d expected=14", n); end
  endtask

  task automatic test_zero_request();
    bit seen; int n;
    cfg_valid = 1; cfg_quarter = 8'd0;
    step();
    cfg_valid = 0;
`ifdef ETH_CLK_DIV_GEN_CFG_CHECK_EN
    checks++; if ({cfg_err, cfg_ready} !== 2'b11) begin errors++;
      $display("FAIL zero_err got=%b expected=11", {cfg_err, cfg_ready}); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL zero_err_pulse got=%b expected=0", cfg_err); end
    measure_low(n);
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL zero_noupd got=%b expected=0", upd); end
    measure_high(n);
    checks++; if (n != 14) begin errors++; $display("FAIL zero_keepq got=%0d expected=14", n); end
`else
    checks++; if ({cfg_err, cfg_ready} !== 2'b00) begin errors++;
      $display("FAIL zero_clamp got=%b expected=00", {cfg_err, cfg_ready}); end
    wait_upd(40, seen);
    checks++; if (!seen) begin errors++; $display("FAIL zero_upd got=none expected=pulse"); end
    measure_high(n);
    checks++; if (n != 2) begin errors++; $display("FAIL zero_q1_high got=%0d expected=2", n); end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen; int n;
    cfg_valid = 1; cfg_quarter = 8'd50;
    step();
    cfg_valid = 0;
    wait_upd(60, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rmid_upd got=none expected=pulse"); end
    n = 0;
    while (!(clk0 === 1'b0 && clk90 === 1'b1) && n < 300) begin n++; step(); end
    checks++; if (n != 100) begin errors++; $display("FAIL rmid_to_phase2 got=%0d expected=100", n); end
    repeat (3) step();
    cfg_valid = 1; cfg_quarter = 8'd5;
    step();
    cfg_valid = 0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rmid_pend got=%b expected=0", cfg_ready); end
    rst = 1;
    step();
    rst = 0;
    checks++; if ({clk0, clk90, clk180, clk270, running, cfg_ready, upd, cfg_err} !== 8'b0011_0100) begin
      errors++;
      $display("FAIL rmid_reset got=%b expected=00110100",
               {clk0, clk90, clk180, clk270, running, cfg_ready, upd, cfg_err});
    end
    step();
    checks++; if ({clk0, running, upd} !== 3'b110) begin errors++;
      $display("FAIL rmid_restart got=%b expected=110", {clk0, running, upd}); end
    step();
    checks++; if ({clk0, clk90} !== 2'b11) begin errors++;
      $display("FAIL rmid_resetq got=%b expected=11", {clk0, clk90}); end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 249) == 0);
      en          = ($urandom_range(0, 5) != 0);
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_quarter = 8'($urandom_range(0, 6));
      step();
    end
    rst = 0; cfg_valid = 0;
  endtask

  initial begin
    rst = 1; en = 0; cfg_valid = 0; cfg_quarter = 0;
    test_reset();
    test_q1_run();
    test_divisor_change();
    test_stop_restart();
    test_back_to_back_cfg();
    test_zero_request();
    test_reset_mid();
    test_random_traffic();
    en = 0;
    step(); step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_clk_div_gen.md
# eth_clk_div_gen

Programmable quadrature clock generator for the Ethernet PHY interface. It divides a fast source clock into four phase-aligned outputs (0°, 90°, 180°, 270°) with a run-time selectable quarter-period, which covers 125/25/2.5 MHz RGMII rates from one source. Divisor changes and start/stop are applied only at period boundaries, so no output ever produces a pulse shorter than one quarter-period. It sits between the FLL output and the Ethernet MAC/PHY pads.

## Interface
- `QuarterWidth`, 8: width of the quarter-period count Q, in source cycles.
- `ResetQuarter`, 1: Q after reset. With a 500 MHz source, Q=1 gives 125 MHz.
- `clk_i`  in  1  source clock (e.g. 500 MHz from FLL)
- `rst_i`  in  1  reset; one clock, synchronous, active-high
- `en_i`  in  1  run request; level-sensitive
- `cfg_valid_i`  in  1  new quarter-period offered
- `cfg_quarter_i`  in  QuarterWidth  requested Q
- `cfg_ready_o`  out  1  pending slot free
- `cfg_err_o`  out  1  one-cycle pulse: request rejected (see Configuration)
- `upd_o`  out  1  one-cycle pulse: new Q took effect
- `running_o`  out  1  state is RUN
- `clk0_o`, `clk90_o`, `clk180_o`, `clk270_o`  out  1 each  registered phase outputs

## Operation
- Registers:
  - `q_q` holds the active Q.
  - `qcnt_q` counts 0..Q-1.
  - `phase_q` is 2 bits.
  - `pend_q`/`pend_valid_q` form a one-entry pending configuration.
- Phase decode, all outputs from flops:
  - `clk0` = phase∈{0,1}.
  - `clk90` = phase∈{1,2}.
  - `clk180` = phase∈{2,3}.
  - `clk270` = phase∈{3,0}.
- Output period is 4Q source cycles at 50% duty. Each output lags the previous one by Q cycles.
- FSM states are STOPPED and RUN.
  - **STOPPED:** outputs hold the phase-3 decode (0,0,1,1), `running_o`=0.
    - If `en_i`=1: go to RUN, set `phase`←0, `qcnt`←0, apply the pending configuration if present.
  - **RUN:** if `qcnt`=Q-1, then `qcnt`←0 and:
    - **Boundary (phase=3):** apply the pending configuration if present. If `en_i`=0, go to STOPPED and keep phase at 3. Otherwise set phase←0.
    - **Not a boundary:** phase←phase+1.
  - **RUN, otherwise:** `qcnt`++.
- `en_i` is sampled only at boundaries. Deasserting and reasserting it between boundaries has no effect.
- Configuration handshake:
  - `cfg_ready_o` = !`pend_valid_q`.
  - A transfer completes when valid & ready; `pend_q` captures `cfg_quarter_i`.
  - Applying the pending value means: `q_q`←`pend_q`, clear `pend_valid_q`, pulse `upd_o`.
- A handshake in the same cycle as a boundary is captured and applied at the next boundary, not the current one.
- Compare `qcnt` against Q-1 at the full `QuarterWidth`. Q is never 0 internally.

## Timing
- Reset values:
  - STOPPED, `phase`=3, `qcnt`=0, `q_q`=`ResetQuarter`, no pending configuration.
  - `clk0`/`clk90`=0, `clk180`/`clk270`=1.
  - `cfg_ready_o`=1, `upd_o`=0, `cfg_err_o`=0, `running_o`=0.
- Start latency: `en_i` high at edge k puts the phase-0 decode on the outputs after edge k (one cycle).
- Stop: the outputs freeze after the edge that ends phase 3. The shortest phase width is Q cycles, both on stop and on restart.
- Divisor change: `upd_o` is high in the cycle after the boundary edge. The first phase at the new Q starts at that edge.
- Reset asserted mid-period: all registers return to reset values on the next edge. Any pending configuration is discarded.

## Configuration
- Macro `ETH_CLK_DIV_GEN_CFG_CHECK_EN` controls what happens to a request with Q=0.
  - **Defined:** the handshake completes, the value is discarded, `pend_valid_q` is unchanged, and `cfg_err_o` pulses for one cycle.
  - **Undefined:** Q=0 is clamped to 1 and treated as a normal request, and `cfg_err_o` is tied to 0.

## Structure
- Package `eth_clk_pkg` holds:
  - the FSM state enum (`CLK_STOPPED`, `CLK_RUN`);
  - the quarter-period presets `Q_125M`=1, `Q_25M`=5, `Q_2M5`=50, which assume a 500 MHz source.
- No sub-module: the counter, FSM and decode live in one module.

## Test plan
- Reset, then `en_i`=1 with Q=1 → a 4-cycle period; `clk90` lags `clk0` by 1 cycle; 180/270 are the complements of 0/90.
- While running at Q=1, request Q=5 mid-period → `cfg_ready_o` drops, `upd_o` pulses after the phase-3 edge, and the next period is 20 cycles with no pulse shorter than 1 cycle.
- Drop `en_i` in phase 1 at Q=5 → the period completes, outputs freeze at (0,0,1,1) and `running_o`=0. Reasserting `en_i` gives `clk0`=1 one cycle later.
- Send a request while one is pending → no transfer until the boundary, then the second value applies at the following boundary.
- Request Q=0 → with the macro, `cfg_err_o` pulses and Q is unchanged; without it, the period becomes 4 cycles.
- Assert `rst_i` mid-phase 2 at Q=50 with a pending configuration → the next cycle shows the reset values and `cfg_ready_o`=1.
